// File: rtl/select_arbiter.sv
// -----------------------------------------------------------------------------
// select_arbiter
//
// Round-robin, burst-locked arbiter that shares one NUM_SEL-to-1 lane selector
// among NUM_SEL requesters. Once a lane is granted it keeps the selector until
// its last beat is accepted. The selected beat lands in a single-entry
// valid/ready output register.
//
// Handshake rule (both sides): a beat moves on a rising clk edge exactly when
// valid and ready are both high in the cycle before that edge. Valid never
// depends on ready. The output stage keeps out_data/out_sel/out_last stable
// while out_valid is high and out_ready is low.
//
// Ports
//   clk        : clock, all state on rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : [NUM_SEL] lane i presents a beat
//   req_last   : [NUM_SEL] lane i beat ends its burst
//   req_ready  : [NUM_SEL] lane i beat accepted (only the granted lane in LOCK)
//   data_in    : [NUM_WIDTH*NUM_SEL] lane i at [NUM_WIDTH*i +: NUM_WIDTH]
//   out_valid  : output register holds a beat
//   out_ready  : downstream accepts the beat
//   out_data   : [NUM_WIDTH] registered selected word
//   out_sel    : [NUM_LOG] lane index of out_data
//   out_last   : registered req_last of that beat
//   busy       : FSM is in LOCK (also serves as the state debug view)
// -----------------------------------------------------------------------------
module select_arbiter #(
    parameter int NUM_SEL   = 16,
    parameter int NUM_LOG   = 4,
    parameter int NUM_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SEL-1:0]           req_valid,
    input  logic [NUM_SEL-1:0]           req_last,
    output logic [NUM_SEL-1:0]           req_ready,
    input  logic [NUM_WIDTH*NUM_SEL-1:0] data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_WIDTH-1:0]         out_data,
    output logic [NUM_LOG-1:0]           out_sel,
    output logic                         out_last,
    output logic                         busy
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_LOG-1:0]   grant_q, grant_d;
    logic [NUM_LOG-1:0]   ptr_q, ptr_d;

    logic                 out_valid_q, out_valid_d;
    logic [NUM_WIDTH-1:0] out_data_q, out_data_d;
    logic [NUM_LOG-1:0]   out_sel_q, out_sel_d;
    logic                 out_last_q, out_last_d;

    logic                 found;
    logic [NUM_LOG-1:0]   pick;
    logic [NUM_LOG-1:0]   idx;
    logic                 can_accept;
    logic                 xfer;
    logic [NUM_WIDTH-1:0] sel_data;
    logic [NUM_LOG-1:0]   grant_inc;

    // Round-robin search starting at ptr_q and wrapping at NUM_SEL.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_SEL; k++) begin
            idx = NUM_LOG'((int'(ptr_q) + k) % NUM_SEL);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Output register can take a beat if empty or being drained this cycle.
    assign can_accept = ~out_valid_q | out_ready;
    assign xfer       = (state_q == LOCK) && req_valid[grant_q] && can_accept;
    assign sel_data   = data_in[int'(grant_q)*NUM_WIDTH +: NUM_WIDTH];
    // Wrap at NUM_SEL, not at 2**NUM_LOG.
    assign grant_inc  = (grant_q == NUM_LOG'(NUM_SEL - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state_q == LOCK && can_accept) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    // Arbitration FSM next state.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (xfer && req_last[grant_q]) begin
                    ptr_d   = grant_inc;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stage next state: load on transfer, clear on drain-only.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = grant_q;
            out_last_d  = req_last[grant_q];
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == LOCK);

endmodule

// File: tb/tb_select_arbiter.sv
// Directed bench for select_arbiter (NUM_SEL=16, NUM_LOG=4, NUM_WIDTH=64).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
module tb_select_arbiter;

  localparam int NS = 16;
  localparam int NL = 4;
  localparam int NW = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NS-1:0]    req_valid;
  logic [NS-1:0]    req_last;
  logic [NS-1:0]    req_ready;
  logic [NW*NS-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [NW-1:0]    out_data;
  logic [NL-1:0]    out_sel;
  logic             out_last;
  logic             busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  select_arbiter #(.NUM_SEL(NS), .NUM_LOG(NL), .NUM_WIDTH(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .busy      (busy)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic v, input logic l, input logic [NW-1:0] d);
    req_valid[lane] = v;
    req_last[lane] = l;
    data_in[lane*NW +: NW] = d;
  endtask

  task automatic clear_all();
    req_valid = '0;
    req_last = '0;
  endtask

  task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [NW-1:0] d,
                         input logic [NL-1:0] s, input logic l);
    chk({tag, ".out_valid"}, NW'(out_valid), NW'(v));
    chk({tag, ".out_data"}, out_data, d);
    chk({tag, ".out_sel"}, NW'(out_sel), NW'(s));
    chk({tag, ".out_last"}, NW'(out_last), NW'(l));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    req_valid = '0;
    req_last = '0;
    data_in = '0;
    out_ready = 1'b1;

    // Reset state
    #12;
    chk_out("reset", 1'b0, '0, '0, 1'b0);
    chk("reset.req_ready", NW'(req_ready), '0);
    chk("reset.busy", NW'(busy), '0);
    rst_n = 1'b1;

    // ---- Single lane 5, three beats ----
    tick();
    set_lane(5, 1'b1, 1'b0, 64'hA0);
    #1;
    chk("s5.idle_ready", NW'(req_ready), '0);
    chk("s5.idle_busy", NW'(busy), '0);
    tick();
    #1;
    chk("s5.lock_busy", NW'(busy), 1);
    chk("s5.lock_ready", NW'(req_ready), NW'(16'h0020));
    chk("s5.c1_valid", NW'(out_valid), '0);
    tick();
    set_lane(5, 1'b1, 1'b0, 64'hA1);
    #1;
    chk_out("s5.b0", 1'b1, 64'hA0, 4'd5, 1'b0);
    tick();
    set_lane(5, 1'b1, 1'b1, 64'hA2);
    #1;
    chk_out("s5.b1", 1'b1, 64'hA1, 4'd5, 1'b0);
    tick();
    clear_all();
    #1;
    chk_out("s5.b2", 1'b1, 64'hA2, 4'd5, 1'b1);
    chk("s5.after_busy", NW'(busy), '0);
    chk("s5.after_ready", NW'(req_ready), '0);
    tick();
    #1;
    chk("s5.drained", NW'(out_valid), '0);

    // ---- ptr now 6: lanes 4,5,7 request -> 7 first, then 4 ----
    set_lane(4, 1'b1, 1'b1, 64'hD4);
    set_lane(5, 1'b1, 1'b1, 64'hD5);
    set_lane(7, 1'b1, 1'b1, 64'hD7);
    tick();
    #1;
    chk("rr.grant7", NW'(req_ready), NW'(16'h0080));
    tick();
    #1;
    chk_out("rr.out7", 1'b1, 64'hD7, 4'd7, 1'b1);
    chk("rr.bubble", NW'(busy), '0);
    tick();
    #1;
    chk("rr.grant4", NW'(req_ready), NW'(16'h0010));
    chk("rr.g4_valid", NW'(out_valid), '0);
    tick();
    clear_all();
    #1;
    chk_out("rr.out4", 1'b1, 64'hD4, 4'd4, 1'b1);

    // ---- Wrap: lane 14 sets ptr=15, then lanes 15 and 0 ----
    set_lane(14, 1'b1, 1'b1, 64'hE14);
    tick();
    #1;
    chk("wr.grant14", NW'(req_ready), NW'(16'h4000));
    tick();
    clear_all();
    set_lane(15, 1'b1, 1'b1, 64'hE15);
    set_lane(0, 1'b1, 1'b1, 64'hE00);
    #1;
    chk_out("wr.out14", 1'b1, 64'hE14, 4'd14, 1'b1);
    tick();
    #1;
    chk("wr.grant15", NW'(req_ready), NW'(16'h8000));
    tick();
    set_lane(15, 1'b0, 1'b0, 64'hE15);
    #1;
    chk_out("wr.out15", 1'b1, 64'hE15, 4'd15, 1'b1);
    tick();
    #1;
    chk("wr.grant0", NW'(req_ready), NW'(16'h0001));
    tick();
    clear_all();
    #1;
    chk_out("wr.out0", 1'b1, 64'hE00, 4'd0, 1'b1);

    // ---- Backpressure: lane 2 burst of 4 ----
    set_lane(2, 1'b1, 1'b0, 64'hB0);
    tick();
    #1;
    chk("bp.grant2", NW'(req_ready), NW'(16'h0004));
    tick();
    set_lane(2, 1'b1, 1'b0, 64'hB1);
    #1;
    chk_out("bp.b0", 1'b1, 64'hB0, 4'd2, 1'b0);
    chk("bp.ready_drain", NW'(req_ready), NW'(16'h0004));
    tick();
    set_lane(2, 1'b1, 1'b0, 64'hB2);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_out("bp.hold", 1'b1, 64'hB1, 4'd2, 1'b0);
      chk("bp.ready_low", NW'(req_ready), '0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk_out("bp.still_b1", 1'b1, 64'hB1, 4'd2, 1'b0);
    chk("bp.ready_back", NW'(req_ready), NW'(16'h0004));
    tick();
    set_lane(2, 1'b1, 1'b1, 64'hB3);
    #1;
    chk_out("bp.b2", 1'b1, 64'hB2, 4'd2, 1'b0);
    tick();
    clear_all();
    #1;
    chk_out("bp.b3", 1'b1, 64'hB3, 4'd2, 1'b1);
    chk("bp.idle", NW'(busy), '0);

    // ---- Lock hold: ptr=3, lane 7 wins over lane 1 and stalls ----
    set_lane(7, 1'b1, 1'b0, 64'h70);
    set_lane(1, 1'b1, 1'b1, 64'h11);
    tick();
    #1;
    chk("lk.grant7", NW'(req_ready), NW'(16'h0080));
    tick();
    set_lane(7, 1'b0, 1'b0, 64'h70);
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("lk.held", NW'(req_ready), NW'(16'h0080));
      chk("lk.busy", NW'(busy), 1);
      tick();
    end
    set_lane(7, 1'b1, 1'b1, 64'h71);
    #1;
    chk("lk.out_empty", NW'(out_valid), '0);
    tick();
    #1;
    chk_out("lk.out71", 1'b1, 64'h71, 4'd7, 1'b1);
    chk("lk.lane1_wait", NW'(req_ready), '0);
    tick();
    #1;
    chk("lk.grant1", NW'(req_ready), NW'(16'h0002));
    tick();
    clear_all();
    #1;
    chk_out("lk.out11", 1'b1, 64'h11, 4'd1, 1'b1);

    // ---- Reset mid-burst on lane 9 (ptr=2) ----
    set_lane(9, 1'b1, 1'b0, 64'h90);
    tick();
    #1;
    chk("rs.grant9", NW'(req_ready), NW'(16'h0200));
    tick();
    #1;
    chk_out("rs.out90", 1'b1, 64'h90, 4'd9, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("rs.async", 1'b0, '0, '0, 1'b0);
    chk("rs.async_ready", NW'(req_ready), '0);
    chk("rs.async_busy", NW'(busy), '0);

    // ---- All 16 lanes request 1-beat bursts continuously ----
    for (int i = 0; i < NS; i++) begin
      set_lane(i, 1'b1, 1'b1, 64'hC0 + 64'(i));
    end
    #1;
    rst_n = 1'b1;
    for (int k = 0; k <= NS; k++) begin
      tick();
      #1;
      chk("all.ready", NW'(req_ready), NW'(1) << (k % NS));
      chk("all.busy", NW'(busy), 1);
      tick();
      #1;
      chk_out("all.out", 1'b1, 64'hC0 + 64'(k % NS), NL'(k % NS), 1'b1);
      chk("all.bubble", NW'(busy), '0);
    end
    clear_all();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
